// File: rtl/ft_regfile_pkg.sv
// Shared types and SEC-DED (extended Hamming) coding helpers for ft_regfile.
// Codeword bit i is Hamming position i; bit 0 is the overall-parity bit.
package ft_regfile_pkg;

    localparam int MAX_DW = 64;
    localparam int MAX_P  = 7;
    localparam int MAX_CW = MAX_DW + MAX_P + 1;

    typedef enum logic {SCAN, FIX} scrub_state_t;

    typedef struct packed {
        logic [MAX_DW-1:0] data;
        logic [MAX_CW-1:0] cw;
        logic              sec;
        logic              ded;
    } dec_t;

    function automatic int calc_parity_bits(input int dw);
        int p;
        p = 0;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    function automatic logic [MAX_CW-1:0] encode(input logic [MAX_DW-1:0] data,
                                                 input int dw, input int p);
        logic [MAX_CW-1:0] cw;
        logic              par;
        int                j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos < MAX_CW; pos++)
            if (pos <= dw + p && (pos & (pos - 1)) != 0) begin
                cw[pos] = data[j];
                j++;
            end
        for (int i = 0; i < MAX_P; i++)
            if (i < p) begin
                par = 1'b0;
                for (int pos = 1; pos < MAX_CW; pos++)
                    if (pos <= dw + p && pos[i]) par = par ^ cw[pos];
                cw[1 << i] = par;
            end
        cw[0] = ^cw;
        return cw;
    endfunction

    // Odd overall parity means one flip (syndrome 0 points at the parity bit itself);
    // even parity with a non-zero syndrome is a double error and the raw word is kept.
    function automatic dec_t decode(input logic [MAX_CW-1:0] cw_in, input int dw, input int p);
        dec_t              r;
        logic [MAX_CW-1:0] c;
        logic              ovr;
        int                s;
        int                j;
        c   = cw_in;
        s   = 0;
        ovr = 1'b0;
        for (int pos = 0; pos < MAX_CW; pos++)
            if (pos <= dw + p) begin
                ovr = ovr ^ c[pos];
                for (int i = 0; i < MAX_P; i++)
                    if (i < p && pos[i]) s[i] = s[i] ^ c[pos];
            end
        r.sec = 1'b0;
        r.ded = 1'b0;
        if (ovr) begin
            if (s <= dw + p) begin
                c[s]  = ~c[s];
                r.sec = 1'b1;
            end else begin
                r.ded = 1'b1;
            end
        end else if (s != 0) begin
            r.ded = 1'b1;
        end
        r.cw   = r.ded ? cw_in : c;
        r.data = '0;
        j      = 0;
        for (int pos = 1; pos < MAX_CW; pos++)
            if (pos <= dw + p && (pos & (pos - 1)) != 0) begin
                r.data[j] = r.cw[pos];
                j++;
            end
        return r;
    endfunction

endpackage

// File: rtl/ft_regfile_secded_dec.sv
// Combinational SEC-DED decoder: corrected data, corrected codeword and error flags.
module secded_dec
    import ft_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int P          = calc_parity_bits(DATA_WIDTH),
    parameter int CW         = DATA_WIDTH + P + 1
) (
    input  logic [CW-1:0]         cw,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CW-1:0]         cw_fix,
    output logic                  sec,
    output logic                  ded
);

    always_comb begin
        dec_t r;
        r      = decode(MAX_CW'(cw), DATA_WIDTH, P);
        data   = r.data[DATA_WIDTH-1:0];
        cw_fix = r.cw[CW-1:0];
        sec    = r.sec;
        ded    = r.ded;
    end

endmodule

// File: rtl/ft_regfile.sv
// SEC-DED protected register file, 1W/NUM_READ-R, with fault injection.
// Define FT_REGFILE_SCRUB_EN to build the background scrubber.
module ft_regfile
    import ft_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_READ    = 2,
    parameter int ZERO_REG_EN = 1,
    parameter int P           = calc_parity_bits(DATA_WIDTH),
    parameter int CW          = DATA_WIDTH + P + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_READ-1:0]            rerr_sec_o,
    output logic [NUM_READ-1:0]            rerr_ded_o,
    input  logic [ADDR_WIDTH-1:0]          waddr_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic                           we_i,
    input  logic                           inj_en_i,
    input  logic [ADDR_WIDTH-1:0]          inj_addr_i,
    input  logic [CW-1:0]                  inj_mask_i,
    input  logic                           scrub_en_i,
    output logic [ADDR_WIDTH-1:0]          scrub_addr_o,
    output logic [15:0]                    sec_cnt_o,
    output logic                           ded_sticky_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR =
        (ZERO_REG_EN != 0) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0);

    logic [CW-1:0]         mem [DEPTH];
    logic [CW-1:0]         wenc;
    logic                  wb_en;
    logic [CW-1:0]         wb_cw;
    logic [ADDR_WIDTH-1:0] scrub_addr;

    always_comb begin
        logic [MAX_CW-1:0] e;
        e    = encode(MAX_DW'(wdata_i), DATA_WIDTH, P);
        wenc = e[CW-1:0];
    end

    // Scrub write-back only fires with we_i low, so it never races a port write.
    for (genvar a = 0; a < DEPTH; a++) begin : g_word
        logic [CW-1:0] q;
        if (ZERO_REG_EN != 0 && a == 0) begin : g_zero
            assign q = '0;
        end else begin : g_reg
            logic [CW-1:0] d;
            always_comb begin
                d = q;
                if (we_i && waddr_i == ADDR_WIDTH'(a))           d = wenc;
                else if (wb_en && scrub_addr == ADDR_WIDTH'(a)) d = wb_cw;
                if (inj_en_i && inj_addr_i == ADDR_WIDTH'(a))    d = d ^ inj_mask_i;
            end
            always_ff @(posedge clk or posedge rst)
                if (rst) q <= '0;
                else     q <= d;
        end
        assign mem[a] = q;
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] d;
        logic                  s, e, z;
        assign ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign z  = (ZERO_REG_EN != 0) && (ra == '0);
        secded_dec #(.DATA_WIDTH(DATA_WIDTH), .P(P), .CW(CW)) u_dec (
            .cw(mem[ra]), .data(d), .cw_fix(), .sec(s), .ded(e)
        );
        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = z ? '0 : d;
        assign rerr_sec_o[k] = s & ~z;
        assign rerr_ded_o[k] = e & ~z;
    end

`ifdef FT_REGFILE_SCRUB_EN
    scrub_state_t  state;
    logic [CW-1:0] s_fix;
    logic          s_sec, s_ded;
    logic [15:0]   sec_cnt;
    logic          ded_sticky;

    secded_dec #(.DATA_WIDTH(DATA_WIDTH), .P(P), .CW(CW)) u_sdec (
        .cw(mem[scrub_addr]), .data(), .cw_fix(s_fix), .sec(s_sec), .ded(s_ded)
    );

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(DEPTH - 1)) ? FIRST_ADDR : a + 1'b1;
    endfunction

    assign wb_en = (state == FIX) && scrub_en_i && !we_i;

    // A port write landing on the word being flagged supersedes it, so no fix is queued.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= SCAN;
            scrub_addr <= FIRST_ADDR;
            wb_cw      <= '0;
            sec_cnt    <= '0;
            ded_sticky <= 1'b0;
        end else if (scrub_en_i) begin
            case (state)
                SCAN:
                    if (s_sec && !(we_i && waddr_i == scrub_addr)) begin
                        wb_cw <= s_fix;
                        state <= FIX;
                    end else begin
                        if (s_ded) ded_sticky <= 1'b1;
                        scrub_addr <= next_addr(scrub_addr);
                    end
                FIX:
                    if (!we_i) begin
                        if (sec_cnt != 16'hFFFF) sec_cnt <= sec_cnt + 16'd1;
                        scrub_addr <= next_addr(scrub_addr);
                        state      <= SCAN;
                    end else if (waddr_i == scrub_addr) begin
                        scrub_addr <= next_addr(scrub_addr);
                        state      <= SCAN;
                    end
                default: state <= SCAN;
            endcase
        end

    assign scrub_addr_o = scrub_addr;
    assign sec_cnt_o    = sec_cnt;
    assign ded_sticky_o = ded_sticky;
`else
    assign wb_en        = 1'b0;
    assign wb_cw        = '0;
    assign scrub_addr   = '0;
    assign scrub_addr_o = '0;
    assign sec_cnt_o    = '0;
    assign ded_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_ft_regfile.sv
// Directed bench for ft_regfile; scrubber checks follow FT_REGFILE_SCRUB_EN.
module tb_ft_regfile;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int CW    = 39;
    localparam int DEPTH = 32;

`ifdef FT_REGFILE_SCRUB_EN
    localparam logic [AW-1:0] EXP_FIRST = 5'd1;
`else
    localparam logic [AW-1:0] EXP_FIRST = 5'd0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rsec, rded;
    logic [AW-1:0]     waddr, inj_addr, scrub_addr;
    logic [DW-1:0]     wdata;
    logic              we, inj_en, scrub_en, ded_sticky;
    logic [CW-1:0]     inj_mask, m;
    logic [15:0]       sec_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ft_regfile dut (
        .clk(clk), .rst(rst),
        .raddr_i(raddr), .rdata_o(rdata), .rerr_sec_o(rsec), .rerr_ded_o(rded),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .inj_en_i(inj_en), .inj_addr_i(inj_addr), .inj_mask_i(inj_mask),
        .scrub_en_i(scrub_en), .scrub_addr_o(scrub_addr),
        .sec_cnt_o(sec_cnt), .ded_sticky_o(ded_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic inj(input logic [AW-1:0] a, input logic [CW-1:0] mask);
        inj_en = 1'b1; inj_addr = a; inj_mask = mask;
        tick();
        inj_en = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    initial begin
        rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = 1'b0;
        inj_en = 1'b0; inj_addr = '0; inj_mask = '0; scrub_en = 1'b0; m = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        rd(10, 11);
        check("rst_rd0", rdata[31:0], 0);
        check("rst_rd1", rdata[63:32], 0);
        check("rst_flags", {rsec, rded}, 0);
        check("rst_scrub_addr", scrub_addr, EXP_FIRST);
        check("rst_sec_cnt", sec_cnt, 0);
        check("rst_sticky", ded_sticky, 0);

        wr(10, 100); wr(11, 69); rd(10, 11);
        check("wr_rd0", rdata[31:0], 100);
        check("wr_rd1", rdata[63:32], 69);
        check("wr_flags", {rsec, rded}, 0);

        wr(10, 69);
        m = '0; m[3] = 1'b1;
        inj(10, m); rd(10, 11);
        check("sec_rd0", rdata[31:0], 69);
        check("sec_flag", rsec, 2'b01);
        check("sec_ded", rded, 2'b00);

        scrub_en = 1'b1;
        repeat (DEPTH + 2) tick();
        scrub_en = 1'b0;
        rd(10, 11);
        check("scrub_rd0", rdata[31:0], 69);
`ifdef FT_REGFILE_SCRUB_EN
        check("scrub_sec_clear", rsec[0], 0);
        check("scrub_cnt", sec_cnt, 1);
`else
        check("noscrub_sec_kept", rsec[0], 1);
        check("noscrub_cnt", sec_cnt, 0);
        check("noscrub_addr", scrub_addr, 0);
`endif

        wr(11, 133);
        m = '0; m[3] = 1'b1; m[7] = 1'b1;
        inj(11, m); rd(10, 11);
        check("ded_raw", rdata[63:32], 140);
        check("ded_flag", rded, 2'b10);
        check("ded_nosec", rsec[1], 0);

        scrub_en = 1'b1;
        repeat (DEPTH + 2) tick();
        scrub_en = 1'b0;
        rd(10, 11);
        check("ded_kept_raw", rdata[63:32], 140);
        check("ded_kept_flag", rded[1], 1);
`ifdef FT_REGFILE_SCRUB_EN
        check("ded_sticky", ded_sticky, 1);
        check("ded_cnt", sec_cnt, 1);
`else
        check("noscrub_sticky", ded_sticky, 0);
`endif

        wr(0, 32'hDEADBEEF); rd(0, 11);
        check("x0_wr", rdata[31:0], 0);
        check("x0_wr_flags", {rsec[0], rded[0]}, 0);
        m = 39'h7F;
        inj(0, m); rd(0, 11);
        check("x0_inj", rdata[31:0], 0);
        check("x0_inj_flags", {rsec[0], rded[0]}, 0);

        wr(5, 3); rd(5, 11);
        we = 1'b1; waddr = 5; wdata = 7;
        #1;
        check("same_cycle_old", rdata[31:0], 3);
        tick();
        we = 1'b0;
        rd(5, 11);
        check("next_cycle_new", rdata[31:0], 7);

`ifdef FT_REGFILE_SCRUB_EN
        m = '0; m[3] = 1'b1;
        inj(5, m); rd(5, 20);
        check("x5_sec", rsec[0], 1);
        scrub_en = 1'b1;
        for (int n = 0; n < 2 * DEPTH && scrub_addr != 5'd5; n++) tick();
        check("reach_x5", scrub_addr, 5);
        tick();
        we = 1'b1; waddr = 20; wdata = 9;
        tick();
        check("fix_hold_addr", scrub_addr, 5);
        waddr = 5; wdata = 42;
        tick();
        we = 1'b0; scrub_en = 1'b0;
        check("drop_addr", scrub_addr, 6);
        check("drop_cnt", sec_cnt, 1);
        rd(5, 20);
        check("drop_x5", rdata[31:0], 42);
        check("drop_x5_flags", {rsec, rded}, 0);
        check("drop_x20", rdata[63:32], 9);

        inj(5, m);
        scrub_en = 1'b1;
        for (int n = 0; n < 2 * DEPTH && scrub_addr != 5'd5; n++) tick();
        check("reach_x5_again", scrub_addr, 5);
        tick();
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0; scrub_en = 1'b0;
        rd(5, 10);
        check("rst2_cnt", sec_cnt, 0);
        check("rst2_addr", scrub_addr, EXP_FIRST);
        check("rst2_sticky", ded_sticky, 0);
        check("rst2_rd0", rdata[31:0], 0);
        check("rst2_rd1", rdata[63:32], 0);
        check("rst2_flags", {rsec, rded}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ft_regfile.md
# ft_regfile

Parametrised, fault-tolerant successor to the single-write/dual-read GPR file. Every word is stored as a SEC-DED (extended Hamming) codeword. Reads return corrected data with per-port error flags. A background scrubber repairs single-bit upsets in idle write cycles. Sits in the core's ID stage in place of the plain GPR file, with a test-only fault-injection port for campaign benches.

## Interface
- ADDR_WIDTH, 5: address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: data bits per register.
- NUM_READ, 2: number of combinational read ports.
- ZERO_REG_EN, 1: address 0 reads 0, writes to it ignored.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- raddr_i  in  NUM_READ*ADDR_WIDTH  packed read addresses, port k at slice k.
- rdata_o  out  NUM_READ*DATA_WIDTH  corrected read data.
- rerr_sec_o  out  NUM_READ  single-bit error corrected on port k.
- rerr_ded_o  out  NUM_READ  uncorrectable double error on port k.
- waddr_i  in  ADDR_WIDTH  write address.
- wdata_i  in  DATA_WIDTH  write data.
- we_i  in  1  write enable.
- inj_en_i  in  1  fault-injection strobe.
- inj_addr_i  in  ADDR_WIDTH  injection target.
- inj_mask_i  in  CW  XOR mask on stored codeword (CW = DATA_WIDTH+P+1).
- scrub_en_i  in  1  scrubber enable (scrub builds only).
- scrub_addr_o  out  ADDR_WIDTH  address the scrubber is checking.
- sec_cnt_o  out  16  scrubber corrections, saturating.
- ded_sticky_o  out  1  sticky: any double error seen by scrubber.

## Operation
- P = smallest value with 2**P >= DATA_WIDTH+P+1 (6 for 32 bits), so CW = 39 at defaults.
- Write: on we_i, store encode(wdata_i) at waddr_i.
- Read: decode the stored word at raddr_i[k] combinationally.
  - Single error: flipped bit corrected, rerr_sec_o[k]=1.
  - Double error: raw data bits output, rerr_ded_o[k]=1.
  - Error in the overall-parity bit alone: counts as SEC.
- ZERO_REG_EN: address 0 returns 0 with both flags low. Writes, injections and scrubs to address 0 are ignored.
- Injection: on inj_en_i, stored[inj_addr_i] ^= inj_mask_i. If a write hits the same address in the same cycle, the mask is applied to the newly encoded word.
- Scrubber FSM:
  - SCAN: decode stored[scrub_addr].
    - Clean: increment address, stay in SCAN.
    - SEC: latch corrected codeword, go to FIX.
    - DED: set ded_sticky_o, increment address, stay in SCAN.
  - FIX: if we_i is low, write back the latched codeword, sec_cnt_o += 1 (saturating), increment address, go to SCAN.
    - If we_i is high to a different address, stay in FIX.
    - If we_i is high to scrub_addr, drop the fix without counting, increment address, go to SCAN.
  - Address wraps DEPTH-1 -> 0, or -> 1 when ZERO_REG_EN.
  - scrub_en_i low: FSM holds its state and does not advance.

## Timing
- Read latency 0 (combinational). No write-to-read bypass: a read of the address being written in the same cycle returns the old value.
- Write visible on reads in the cycle after the edge.
- Scrub cost per clean word: 1 cycle. Per corrected word: 2 cycles minimum.
- Reset: storage all zero (a valid codeword), scrub_addr_o = 1 if ZERO_REG_EN else 0, FSM in SCAN, sec_cnt_o = 0, ded_sticky_o = 0. With storage zero, rdata_o reads 0 and all flags read 0.
- Reset asserted mid-FIX discards the pending write-back.
- ded_sticky_o clears only on rst.

## Configuration
- FT_REGFILE_SCRUB_EN defined: scrubber FSM, scrub_en_i, scrub_addr_o, sec_cnt_o and ded_sticky_o are present and behave as in Operation.
- Not defined: no scrubber logic. Ports remain; scrub_en_i is ignored and the outputs are tied to 0. Read-path correction is unchanged but is never written back.

## Structure
- Package ft_regfile_pkg holds:
  - calc_parity_bits function.
  - encode and decode functions (decode returns data, sec, ded).
  - scrub_state_t enum {SCAN, FIX}.
- Sub-module secded_dec: one combinational decoder instanced NUM_READ times, plus once more in scrub builds.

## Test plan
- Reset, then write 100 to x10 and 69 to x11, read ports (10, 11) -> 100/69, all flags 0.
- Write x10 = 69, then inject mask bit 3 at x10 -> port 0 reads 69 with rerr_sec_o[0] = 1. With scrub_en_i high, within DEPTH+2 cycles x10 reads 69 clean and sec_cnt_o = 1.
- Inject mask bits 3 and 7 at x11 (holding 133) -> rerr_ded_o = 1; the scrubber sets ded_sticky_o and the stored word is left unchanged.
- Write 0xDEADBEEF to x0 -> reads 0; inject at x0 -> still 0, no flags.
- Same-cycle write x5 = 7 and read of x5 -> old value, 7 on the next cycle. Scrubber in FIX on x5 while a write hits x5 -> fix dropped, sec_cnt_o unchanged, x5 = written value.
- Assert rst during FIX -> sec_cnt_o = 0, scrub_addr_o = 1, all reads 0.
